// File: rtl/tmr_rollback_ctrl.sv
// ---------------------------------------------------------------------------
// tmr_rollback_ctrl
//   Rollback/recovery controller that sits between the TMR voter and the three
//   RV cores. It keeps a ring of the last DEPTH fully-voted retired
//   instructions (pc, instr). On a total voter mismatch (3'b000) it:
//     1. holds the cores and loads a rollback PC,
//     2. for each replayed entry, injects restore loads for rd/rs1/rs2 from the
//        register save area and then reissues the instruction,
//     3. pulses recover_done and clears the ring.
//   Every output comes straight from a flop. The next-state values are
//   computed from the next FSM state, so each output lines up with the state
//   it belongs to.
//
// Configuration macro:
//   TMR_ROLLBACK_SCRUB_EN - when defined, a single-core disagreement
//     (110/101/011) on an instruction with rd!=0 triggers a one-cycle SCRUB.
//     SCRUB stores the voted rd to the save area. When the macro is not
//     defined, these patterns are only masked and write_en is tied 0.
//
// Ports:
//   clk, rst_in              clock (rising edge), async active-low reset
//   vote_valid               one voted retired instruction this cycle
//   voter_state[2:0]         per-core agreement bits
//   pc_in, instr_in          voted PC / instruction
//   core_hold                stall all cores (HOLD, SCRUB)
//   recovery_mode            HOLD .. DONE inclusive
//   mux_instr_sel            cores fetch inject_instr instead of IMEM
//   mux_data_sel             core data port routed to the save area
//   write_en                 save-area write enable (SCRUB only)
//   inject_instr             instruction forced into the cores (held otherwise)
//   pc_load, pc_rollback     one-cycle PC load pulse and its target
//   ckpt_count               valid ring entries
//   recover_done             one-cycle pulse in DONE
//   fault_cnt                recoveries entered, saturating at 8'hFF
// ---------------------------------------------------------------------------
module tmr_rollback_ctrl #(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter int          REPLAY_N  = 2,
    parameter logic [11:0] SAVE_BASE = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   vote_valid,
    input  logic [2:0]             voter_state,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [31:0]            instr_in,
    output logic                   core_hold,
    output logic                   recovery_mode,
    output logic                   mux_instr_sel,
    output logic                   mux_data_sel,
    output logic                   write_en,
    output logic [31:0]            inject_instr,
    output logic                   pc_load,
    output logic [XLEN-1:0]        pc_rollback,
    output logic [$clog2(DEPTH):0] ckpt_count,
    output logic                   recover_done,
    output logic [7:0]             fault_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] RN_C    = CW'(REPLAY_N);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RD, S_RS1, S_RS2, S_REISSUE, S_DONE, S_SCRUB
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_q, cur_d;      // ring index of the entry being replayed
    logic [CW-1:0]   left_q, left_d;    // entries still to replay, current included
    logic [AW-1:0]   wp_q;              // next write slot (= oldest when full)
    logic [CW-1:0]   cnt_q;
    logic [7:0]      fault_q;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];

    // Output flops
    logic            hold_q, hold_d;
    logic            rmode_q, rmode_d;
    logic            msel_q, msel_d;
    logic            pcl_q, pcl_d;
    logic            done_q, done_d;
    logic [31:0]     inj_q, inj_d;
    logic [XLEN-1:0] rb_q, rb_d;

    // ---------------- vote decode ----------------
    // Votes are only considered outside recovery (IDLE or SCRUB).
    logic accept, v_full, v_fault, v_scrub, push;
    assign accept  = vote_valid && (state_q == S_IDLE || state_q == S_SCRUB);
    assign v_full  = accept && (voter_state == 3'b111);
    assign v_fault = accept && (voter_state == 3'b000);
`ifdef TMR_ROLLBACK_SCRUB_EN
    assign v_scrub = accept && (voter_state inside {3'b110, 3'b101, 3'b011})
                     && (instr_in[11:7] != 5'd0);
`else
    assign v_scrub = 1'b0;
`endif
    assign push = v_full || v_scrub;

    // The replay window is the newest R entries, walked oldest to newest.
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] first_idx;
    assign r_cnt     = (cnt_q < RN_C) ? cnt_q : RN_C;
    assign first_idx = wp_q - r_cnt[AW-1:0];

    // ---------------- instruction encoders ----------------
    // Save-area offset wraps modulo 4096 (12-bit immediate).
    function automatic logic [11:0] save_off(input logic [4:0] r);
        return SAVE_BASE + {4'b0000, r, 3'b000};
    endfunction

    // LD r, off(x0); x0 needs no restore, so a NOP is injected instead.
    function automatic logic [31:0] ld_op(input logic [4:0] r);
        logic [11:0] off;
        off = save_off(r);
        return (r == 5'd0) ? 32'h0000_0013 : {off, 5'd0, 3'b011, r, 7'b0000011};
    endfunction

`ifdef TMR_ROLLBACK_SCRUB_EN
    // SD r, off(x0)
    function automatic logic [31:0] sd_op(input logic [4:0] r);
        logic [11:0] off;
        off = save_off(r);
        return {off[11:5], r, 5'd0, 3'b011, off[4:0], 7'b0100011};
    endfunction
`endif

    // ---------------- checkpoint ring ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wp_q]  <= pc_in;
            ins_mem[wp_q] <= instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            wp_q    <= '0;
            cnt_q   <= '0;
            fault_q <= '0;
        end else begin
            if (push) begin
                wp_q <= wp_q + 1'b1;
                if (cnt_q != DEPTH_C) cnt_q <= cnt_q + 1'b1;
            end else if (state_q == S_DONE) begin
                cnt_q <= '0;
            end
            if (v_fault && fault_q != 8'hFF) fault_q <= fault_q + 8'd1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            left_q  <= left_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE, S_SCRUB: begin
                if (v_fault) begin
                    state_d = S_HOLD;
                    cur_d   = first_idx;
                    left_d  = r_cnt;
                end else if (v_scrub) begin
                    state_d = S_SCRUB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD:    state_d = (left_q == '0) ? S_DONE : S_RD;
            S_RD:      state_d = S_RS1;
            S_RS1:     state_d = S_RS2;
            S_RS2:     state_d = S_REISSUE;
            S_REISSUE: begin
                if (left_q == CW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD;
                    cur_d   = cur_q + 1'b1;
                    left_d  = left_q - 1'b1;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next-cycle values) ----------------
    always_comb begin
        hold_d  = (state_d == S_HOLD) || (state_d == S_SCRUB);
        rmode_d = state_d inside {S_HOLD, S_RD, S_RS1, S_RS2, S_REISSUE, S_DONE};
        msel_d  = state_d inside {S_RD, S_RS1, S_RS2, S_REISSUE, S_SCRUB};
        pcl_d   = (state_d == S_HOLD);
        done_d  = (state_d == S_DONE);
        rb_d    = rb_q;
        if (v_fault) rb_d = (r_cnt == '0) ? pc_in : pc_mem[first_idx];
        inj_d   = inj_q;
        case (state_d)
            S_RD:      inj_d = ld_op(ins_mem[cur_d][11:7]);
            S_RS1:     inj_d = ld_op(ins_mem[cur_d][19:15]);
            S_RS2:     inj_d = ld_op(ins_mem[cur_d][24:20]);
            S_REISSUE: inj_d = ins_mem[cur_d];
`ifdef TMR_ROLLBACK_SCRUB_EN
            S_SCRUB:   inj_d = sd_op(instr_in[11:7]);
`endif
            default:   inj_d = inj_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            hold_q  <= 1'b0;
            rmode_q <= 1'b0;
            msel_q  <= 1'b0;
            pcl_q   <= 1'b0;
            done_q  <= 1'b0;
            inj_q   <= '0;
            rb_q    <= '0;
        end else begin
            hold_q  <= hold_d;
            rmode_q <= rmode_d;
            msel_q  <= msel_d;
            pcl_q   <= pcl_d;
            done_q  <= done_d;
            inj_q   <= inj_d;
            rb_q    <= rb_d;
        end
    end

`ifdef TMR_ROLLBACK_SCRUB_EN
    logic we_q;
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) we_q <= 1'b0;
        else         we_q <= (state_d == S_SCRUB);
    end
    assign write_en = we_q;
`else
    assign write_en = 1'b0;
`endif

    assign core_hold     = hold_q;
    assign recovery_mode = rmode_q;
    assign mux_instr_sel = msel_q;
    assign mux_data_sel  = msel_q;
    assign inject_instr  = inj_q;
    assign pc_load       = pcl_q;
    assign pc_rollback   = rb_q;
    assign ckpt_count    = cnt_q;
    assign recover_done  = done_q;
    assign fault_cnt     = fault_q;

endmodule

// File: tb/tb_tmr_rollback_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tmr_rollback_ctrl
//   Self-checking bench for tmr_rollback_ctrl. A reference model keeps the
//   checkpoint history as a queue of (pc, instr). On a fault, the model expands
//   a recovery into a queue of per-cycle expected output records. Every cycle,
//   the DUT outputs are compared against the model's record for that cycle.
//   Directed scenarios are followed by randomized votes and occasional
//   asynchronous resets.
// ---------------------------------------------------------------------------
module tb_tmr_rollback_ctrl;
    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 4;
    localparam int          REPLAY_N  = 2;
    localparam logic [11:0] SAVE_BASE = 12'h000;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        vote_valid = 1'b0;
    logic [2:0]  voter_state = 3'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        core_hold, recovery_mode, mux_instr_sel, mux_data_sel, write_en;
    logic [31:0] inject_instr, pc_rollback;
    logic        pc_load, recover_done;
    logic [2:0]  ckpt_count;
    logic [7:0]  fault_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit        hold, rm, msel, pcl, done;
        bit [31:0] inj, pcrb;
        int        cnt, fc;
    } rec_t;

    rec_t        cur;
    rec_t        sched[$];
    logic [31:0] rpc[$];
    logic [31:0] rins[$];
    int          fcnt;

    tmr_rollback_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .REPLAY_N(REPLAY_N), .SAVE_BASE(SAVE_BASE)
    ) dut (
        .clk(clk), .rst_in(rst_in), .vote_valid(vote_valid),
        .voter_state(voter_state), .pc_in(pc_in), .instr_in(instr_in),
        .core_hold(core_hold), .recovery_mode(recovery_mode),
        .mux_instr_sel(mux_instr_sel), .mux_data_sel(mux_data_sel),
        .write_en(write_en), .inject_instr(inject_instr), .pc_load(pc_load),
        .pc_rollback(pc_rollback), .ckpt_count(ckpt_count),
        .recover_done(recover_done), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Restore load: LD r, ((SAVE_BASE + 8r) mod 4096)(x0); NOP for x0.
    function automatic logic [31:0] ld_word(input int r);
        longint imm, w;
        if (r == 0) return 32'h0000_0013;
        imm = (longint'(SAVE_BASE) + r * 8) % 4096;
        w   = imm * 1048576 + 3 * 4096 + r * 128 + 3;
        return w[31:0];
    endfunction

    function automatic int fld(input logic [31:0] ins, input int lsb);
        return int'((ins >> lsb) & 32'h1f);
    endfunction

    function automatic rec_t idle_rec();
        rec_t r = '{default: 0};
        r.inj  = cur.inj;
        r.pcrb = cur.pcrb;
        r.cnt  = rpc.size();
        r.fc   = fcnt;
        return r;
    endfunction

    // Expand a fault into per-cycle expected records: HOLD, 4 per entry, DONE.
    task automatic build_recovery(input logic [31:0] pc);
        int          s, rr;
        rec_t        h, t, d;
        logic [31:0] last;
        s  = rpc.size();
        rr = (s < REPLAY_N) ? s : REPLAY_N;
        h = '{default: 0};
        h.hold = 1; h.rm = 1; h.pcl = 1;
        h.pcrb = (rr == 0) ? pc : rpc[s - rr];
        h.inj = cur.inj; h.cnt = s; h.fc = fcnt;
        sched.push_back(h);
        last = h.inj;
        for (int e = s - rr; e < s; e++) begin
            for (int k = 0; k < 4; k++) begin
                t = '{default: 0};
                t.rm = 1; t.msel = 1; t.pcrb = h.pcrb; t.cnt = s; t.fc = fcnt;
                case (k)
                    0:       t.inj = ld_word(fld(rins[e], 7));
                    1:       t.inj = ld_word(fld(rins[e], 15));
                    2:       t.inj = ld_word(fld(rins[e], 20));
                    default: t.inj = rins[e];
                endcase
                last = t.inj;
                sched.push_back(t);
            end
        end
        d = '{default: 0};
        d.rm = 1; d.done = 1; d.inj = last; d.pcrb = h.pcrb; d.cnt = s; d.fc = fcnt;
        sched.push_back(d);
        rpc.delete();
        rins.delete();
    endtask

    task automatic model_step(input bit v, input logic [2:0] vs,
                              input logic [31:0] pc, input logic [31:0] ins);
        rec_t n;
        if (cur.rm) begin
            if (sched.size() > 0) n = sched.pop_front();
            else                  n = idle_rec();
        end else if (v && vs == 3'b111) begin
            rpc.push_back(pc);
            rins.push_back(ins);
            if (rpc.size() > DEPTH) begin
                rpc.delete(0);
                rins.delete(0);
            end
            n = idle_rec();
        end else if (v && vs == 3'b000) begin
            if (fcnt < 255) fcnt++;
            build_recovery(pc);
            n = sched.pop_front();
        end else begin
            n = idle_rec();
        end
        cur = n;
    endtask

    task automatic check_all(input string p);
        chk({p, ".hold"},  64'(core_hold),     64'(cur.hold));
        chk({p, ".rmode"}, 64'(recovery_mode), 64'(cur.rm));
        chk({p, ".isel"},  64'(mux_instr_sel), 64'(cur.msel));
        chk({p, ".dsel"},  64'(mux_data_sel),  64'(cur.msel));
        chk({p, ".we"},    64'(write_en),      64'(0));
        chk({p, ".inj"},   64'(inject_instr),  64'(cur.inj));
        chk({p, ".pcl"},   64'(pc_load),       64'(cur.pcl));
        chk({p, ".pcrb"},  64'(pc_rollback),   64'(cur.pcrb));
        chk({p, ".cnt"},   64'(ckpt_count),    64'(cur.cnt));
        chk({p, ".done"},  64'(recover_done),  64'(cur.done));
        chk({p, ".fcnt"},  64'(fault_cnt),     64'(cur.fc));
    endtask

    // Called just after a falling edge; compares at the next falling edge.
    task automatic step(input string p, input bit v, input logic [2:0] vs,
                        input logic [31:0] pc, input logic [31:0] ins);
        vote_valid  = v;
        voter_state = vs;
        pc_in       = pc;
        instr_in    = ins;
        model_step(v, vs, pc, ins);
        @(negedge clk);
        check_all(p);
    endtask

    task automatic idle(input string p);
        step(p, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        vote_valid = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        cur = '{default: 0};
        sched.delete();
        rpc.delete();
        rins.delete();
        fcnt = 0;
        check_all("rst");
        @(negedge clk);
        #1 rst_in = 1'b1;
    endtask

    localparam logic [31:0] ADD = 32'h0073_02B3;  // add x5, x6, x7

    initial begin
        logic [2:0] pats[6];
        pats = '{3'b110, 3'b101, 3'b011, 3'b001, 3'b010, 3'b100};
        cur  = '{default: 0};
        fcnt = 0;
        @(negedge clk);
        do_reset();

        // T2: replay of the two newest entries
        step("t2p", 1, 3'b111, 32'h100, ADD);
        step("t2p", 1, 3'b111, 32'h104, ADD);
        step("t2p", 1, 3'b111, 32'h108, ADD);
        step("t2f", 1, 3'b000, 32'h10C, 32'h0);
        chk("t2.pcrb", 64'(pc_rollback), 64'h104);
        chk("t2.pcl",  64'(pc_load), 64'(1));
        chk("t2.fcnt", 64'(fault_cnt), 64'(1));
        idle("t2r");  chk("t2.ld_rd",  64'(inject_instr), 64'h0280_3283);
        idle("t2r");  chk("t2.ld_rs1", 64'(inject_instr), 64'h0300_3303);
        idle("t2r");  chk("t2.ld_rs2", 64'(inject_instr), 64'h0380_3383);
        idle("t2r");  chk("t2.reiss",  64'(inject_instr), 64'(ADD));
        for (int i = 0; i < 4; i++) idle("t2r");
        idle("t2d");  chk("t2.done9",  64'(recover_done), 64'(1));
        idle("t2i");  chk("t2.cnt0",   64'(ckpt_count), 64'(0));

        // T3: fault on an empty ring
        do_reset();
        step("t3f", 1, 3'b000, 32'h200, 32'h0);
        chk("t3.pcrb", 64'(pc_rollback), 64'h200);
        idle("t3d");  chk("t3.done", 64'(recover_done), 64'(1));
        idle("t3i");  chk("t3.rmode", 64'(recovery_mode), 64'(0));

        // T4: overflow keeps the newest DEPTH entries
        do_reset();
        for (int i = 0; i < 6; i++) step("t4p", 1, 3'b111, 32'(i * 4), $urandom);
        chk("t4.cnt", 64'(ckpt_count), 64'(4));
        step("t4f", 1, 3'b000, 32'h40, 32'h0);
        chk("t4.pcrb", 64'(pc_rollback), 64'h10);
        for (int i = 0; i < 10; i++) idle("t4r");

        // T5: votes during recovery are ignored; reset mid-recovery aborts it
        do_reset();
        for (int i = 0; i < 3; i++) step("t5p", 1, 3'b111, 32'(32'h300 + i * 4), $urandom);
        step("t5f", 1, 3'b000, 32'h30C, 32'h0);
        idle("t5r");
        idle("t5r");
        step("t5v", 1, 3'b000, 32'h500, 32'h0);
        step("t5v", 1, 3'b111, 32'h504, ADD);
        chk("t5.fcnt", 64'(fault_cnt), 64'(1));
        for (int i = 0; i < 7; i++) idle("t5r");
        for (int i = 0; i < 2; i++) step("t5p", 1, 3'b111, 32'(32'h600 + i * 4), $urandom);
        step("t5f", 1, 3'b000, 32'h60C, 32'h0);
        idle("t5r");
        idle("t5r");
        do_reset();
        idle("t5i");

        // Masked single-core disagreements never push
        for (int i = 0; i < 6; i++) step("mask", 1, pats[i], 32'h700, ADD);
        chk("mask.cnt", 64'(ckpt_count), 64'(0));

`ifdef TMR_ROLLBACK_SCRUB_EN
        // T6: SCRUB stores the voted rd
        do_reset();
        vote_valid = 1; voter_state = 3'b110; pc_in = 32'h800; instr_in = ADD;
        @(negedge clk);
        chk("t6.we",   64'(write_en), 64'(1));
        chk("t6.inj",  64'(inject_instr), 64'h0250_3423);
        chk("t6.hold", 64'(core_hold), 64'(1));
        vote_valid = 0;
        @(negedge clk);
        chk("t6.we0", 64'(write_en), 64'(0));
        chk("t6.cnt", 64'(ckpt_count), 64'(1));
`endif

        // fault_cnt saturation
        do_reset();
        for (int i = 0; i < 800; i++) step("sat", 1, 3'b000, 32'h900, 32'h0);
        chk("sat.fcnt", 64'(fault_cnt), 64'hFF);

        // Randomized votes with occasional async resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int       p;
            bit       v;
            logic [2:0] vs;
            p  = $urandom_range(0, 99);
            v  = (p >= 20);
            if (p < 70)      vs = 3'b111;
            else if (p < 78) vs = 3'b000;
            else begin
`ifdef TMR_ROLLBACK_SCRUB_EN
                vs = pats[3 + $urandom_range(0, 2)];
`else
                vs = pats[$urandom_range(0, 5)];
`endif
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else step("rnd", v, vs, $urandom & 32'hFFFF_FFFC, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
